// File: rtl/brctrl_pkg.sv
// brctrl_pkg: shared types for branch resolve control.
// FSM states, 2-bit counter codes, in-flight queue entry.
package brctrl_pkg;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // value the table takes on an upd_init write
  localparam logic [1:0] INIT_STATE = WT;

  localparam int BR_IDX_W = 6;

  typedef struct packed {
    logic [BR_IDX_W-1:0] idx;
    logic                pred;
    logic [31:0]         alt_pc;
  } br_ent_t;

endpackage

// File: rtl/brctrl_fifo.sv
// brctrl_fifo: in-order queue of in-flight branches.
// Clear wins over push/pop; DEPTH must be a power of 2.
module brctrl_fifo
  import brctrl_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = br_ent_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  input  logic                       clear,
  output T                           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T              mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  // pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // entry storage
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wp] <= din;
  end

  assign head  = mem[rp];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: predictor table sweep, update, redirect/flush.
// Optional BRCTRL_STATS_EN adds resolve/mispredict counters.
module branch_resolve_ctrl
  import brctrl_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int IDX_W     = 6,
  parameter int FLUSH_CYC = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_valid,
  input  logic [IDX_W-1:0]           fetch_idx,
  input  logic                       fetch_pred,
  input  logic [31:0]                fetch_alt_pc,
  output logic                       fetch_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       upd_en,
  output logic [IDX_W-1:0]           upd_idx,
  output logic                       upd_taken,
  output logic                       upd_init,
  output logic                       flush,
  output logic                       redirect_valid,
  output logic [31:0]                redirect_pc,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] inflight
`ifdef BRCTRL_STATS_EN
  ,
  output logic [15:0]                stat_resolved,
  output logic [15:0]                stat_mispred
`endif
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             pred;
    logic [31:0]      alt_pc;
  } ent_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] sweep, sweep_d;
  logic [FW-1:0]    fcnt, fcnt_d;
  logic             upd_en_d, upd_init_d, upd_taken_d;
  logic [IDX_W-1:0] upd_idx_d;
  logic             flush_d, redir_d;
  logic [31:0]      redir_pc_d;

  ent_t din, head;
  logic full, empty;
  logic push, pop, mis;

  // busy lags state by one cycle so the last sweep write retires first
  assign fetch_ready = (state == S_RUN) && !busy && !full;
  assign pop  = (state == S_RUN) && !busy && res_valid && !empty;
  assign mis  = pop && (head.pred != res_taken);
  assign push = fetch_valid && fetch_ready && !mis;
  assign din  = '{idx: fetch_idx, pred: fetch_pred,
                  alt_pc: fetch_alt_pc};

  brctrl_fifo #(
    .DEPTH (DEPTH),
    .T     (ent_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .clear (mis),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (inflight)
  );

  // next state and next registered outputs
  always_comb begin
    state_d     = state;
    sweep_d     = sweep;
    fcnt_d      = fcnt;
    upd_en_d    = 1'b0;
    upd_init_d  = 1'b0;
    upd_idx_d   = upd_idx;
    upd_taken_d = upd_taken;
    flush_d     = 1'b0;
    redir_d     = 1'b0;
    redir_pc_d  = redirect_pc;
    unique case (state)
      S_CLEAR: begin
        upd_en_d   = 1'b1;
        upd_init_d = 1'b1;
        upd_idx_d  = sweep;
        sweep_d    = sweep + IDX_W'(1);
        if (sweep == IDX_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (pop) begin
          upd_en_d    = 1'b1;
          upd_idx_d   = head.idx;
          upd_taken_d = res_taken;
          if (mis) begin
            redir_d    = 1'b1;
            redir_pc_d = head.alt_pc;
            flush_d    = 1'b1;
            fcnt_d     = FW'(FLUSH_CYC - 1);
            state_d    = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (fcnt == '0) begin
          state_d = S_RUN;
        end else begin
          fcnt_d  = fcnt - FW'(1);
          flush_d = 1'b1;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_CLEAR;
      sweep          <= '0;
      fcnt           <= '0;
      upd_en         <= 1'b0;
      upd_init       <= 1'b0;
      upd_idx        <= '0;
      upd_taken      <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b1;
    end else begin
      state          <= state_d;
      sweep          <= sweep_d;
      fcnt           <= fcnt_d;
      upd_en         <= upd_en_d;
      upd_init       <= upd_init_d;
      upd_idx        <= upd_idx_d;
      upd_taken      <= upd_taken_d;
      flush          <= flush_d;
      redirect_valid <= redir_d;
      redirect_pc    <= redir_pc_d;
      busy           <= (state == S_CLEAR);
    end
  end

`ifdef BRCTRL_STATS_EN
  // saturating resolve / mispredict counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else if (state == S_CLEAR) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (pop && stat_resolved != '1)
        stat_resolved <= stat_resolved + 16'd1;
      if (mis && stat_mispred != '1)
        stat_mispred <= stat_mispred + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: scoreboard bench for branch_resolve_ctrl.
// Model queue predicts updates; monitor pops and compares.
module tb_branch_resolve_ctrl;

  localparam int DEPTH     = 4;
  localparam int IDX_W     = 6;
  localparam int FLUSH_CYC = 2;
  localparam int NENT      = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             fetch_valid = 1'b0;
  logic [IDX_W-1:0] fetch_idx = '0;
  logic             fetch_pred = 1'b0;
  logic [31:0]      fetch_alt_pc = '0;
  logic             fetch_ready;
  logic             res_valid = 1'b0;
  logic             res_taken = 1'b0;
  logic             upd_en;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_init;
  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             busy;
  logic [2:0]       inflight;
`ifdef BRCTRL_STATS_EN
  logic [15:0]      stat_resolved;
  logic [15:0]      stat_mispred;
`endif

  branch_resolve_ctrl #(
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .FLUSH_CYC (FLUSH_CYC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_valid    (fetch_valid),
    .fetch_idx      (fetch_idx),
    .fetch_pred     (fetch_pred),
    .fetch_alt_pc   (fetch_alt_pc),
    .fetch_ready    (fetch_ready),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .upd_en         (upd_en),
    .upd_idx        (upd_idx),
    .upd_taken      (upd_taken),
    .upd_init       (upd_init),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .inflight       (inflight)
`ifdef BRCTRL_STATS_EN
    ,
    .stat_resolved  (stat_resolved),
    .stat_mispred   (stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             pred;
    logic [31:0]      pc;
  } br_t;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             taken;
    logic             mis;
    logic [31:0]      pc;
  } exp_t;

  br_t  mq[$];
  exp_t eq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  // advance one edge, then score any resolve update
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (upd_en && !upd_init) begin
      if (eq.size() == 0) begin
        check("upd_unexpected", 32'(upd_en), 0);
      end else begin
        e = eq.pop_front();
        check("upd_idx", 32'(upd_idx), 32'(e.idx));
        check("upd_taken", 32'(upd_taken), 32'(e.taken));
        check("redirect_valid", 32'(redirect_valid), 32'(e.mis));
        check("flush_on_upd", 32'(flush), 32'(e.mis));
        if (e.mis) check("redirect_pc", redirect_pc, e.pc);
      end
    end else begin
      if (eq.size() > 0) begin
        e = eq.pop_front();
        check("upd_missing", 32'(upd_en), 1);
      end
      if (redirect_valid)
        check("redirect_stray", 32'(redirect_valid), 0);
    end
  endtask

  // one RUN cycle of fetch and/or resolve with model update
  task automatic cycle(input logic fv,
                       input logic [IDX_W-1:0] idx,
                       input logic pred,
                       input logic [31:0] pc,
                       input logic rv,
                       input logic tk);
    logic acc;
    logic mis;
    br_t  h;
    check("fetch_ready", 32'(fetch_ready),
          32'(mq.size() < DEPTH));
    acc = fv && (mq.size() < DEPTH);
    mis = 1'b0;
    if (rv && mq.size() > 0) begin
      h   = mq.pop_front();
      mis = (h.pred != tk);
      eq.push_back('{h.idx, tk, mis, h.pc});
      if (mis) mq.delete();
    end
    if (acc && !mis) mq.push_back('{idx, pred, pc});
    fetch_valid  = fv;
    fetch_idx    = idx;
    fetch_pred   = pred;
    fetch_alt_pc = pc;
    res_valid    = rv;
    res_taken    = tk;
    step();
    fetch_valid = 1'b0;
    res_valid   = 1'b0;
    check("inflight", 32'(inflight), 32'(mq.size()));
  endtask

  task automatic flush_out();
    check("flush_first", 32'(flush), 1);
    check("ready_in_flush", 32'(fetch_ready), 0);
    for (int k = 1; k < FLUSH_CYC; k++) begin
      res_valid = 1'b1;
      step();
      res_valid = 1'b0;
      check("flush_hold", 32'(flush), 1);
      check("ready_in_flush", 32'(fetch_ready), 0);
      check("redirect_pulse", 32'(redirect_valid), 0);
    end
    step();
    check("flush_end", 32'(flush), 0);
    check("ready_after_flush", 32'(fetch_ready), 1);
  endtask

  task automatic sweep();
    for (int i = 0; i < NENT; i++) begin
      step();
      check("sweep_en_init_busy",
            {29'd0, upd_en, upd_init, busy}, 32'h7);
      check("sweep_idx", 32'(upd_idx), 32'(i));
      check("sweep_ready", 32'(fetch_ready), 0);
    end
    step();
    check("busy_done", 32'(busy), 0);
    check("ready_done", 32'(fetch_ready), 1);
    check("en_done", 32'(upd_en), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_busy", 32'(busy), 1);
    check("rst_upd_en", 32'(upd_en), 0);
    check("rst_upd_init", 32'(upd_init), 0);
    check("rst_upd_idx", 32'(upd_idx), 0);
    check("rst_upd_taken", 32'(upd_taken), 0);
    check("rst_flush", 32'(flush), 0);
    check("rst_redirect", 32'(redirect_valid), 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_ready", 32'(fetch_ready), 0);
    check("rst_inflight", 32'(inflight), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b1;
    sweep();

    cycle(1'b1, 6'd5, 1'b1, 32'h104, 1'b0, 1'b0);
    cycle(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("correct_no_flush", 32'(flush), 0);

    cycle(1'b1, 6'd9, 1'b0, 32'h200, 1'b0, 1'b0);
    cycle(1'b1, 6'd10, 1'b1, 32'h300, 1'b0, 1'b0);
    cycle(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    flush_out();

    cycle(1'b1, 6'd11, 1'b0, 32'h500, 1'b0, 1'b0);
    cycle(1'b1, 6'd12, 1'b1, 32'h600, 1'b1, 1'b1);
    flush_out();

    cycle(1'b1, 6'd20, 1'b1, 32'h1000, 1'b0, 1'b0);
    cycle(1'b1, 6'd21, 1'b0, 32'h1100, 1'b0, 1'b0);
    cycle(1'b1, 6'd22, 1'b1, 32'h1200, 1'b0, 1'b0);
    cycle(1'b1, 6'd23, 1'b1, 32'h1300, 1'b0, 1'b0);
    check("full_inflight", 32'(inflight), 4);
    check("full_not_ready", 32'(fetch_ready), 0);
    cycle(1'b1, 6'd30, 1'b1, 32'h9990, 1'b1, 1'b1);
    check("full_pop_inflight", 32'(inflight), 3);
    cycle(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 1'b1);

    cycle(1'b1, 6'd40, 1'b1, 32'h4000, 1'b0, 1'b0);
    cycle(1'b1, 6'd41, 1'b0, 32'h4100, 1'b1, 1'b1);
    check("push_pop_inflight", 32'(inflight), 1);
    cycle(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    flush_out();

    cycle(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("empty_res_no_upd", 32'(upd_en), 0);
    check("empty_res_no_flush", 32'(flush), 0);

    cycle(1'b1, 6'd7, 1'b1, 32'h700, 1'b0, 1'b0);
    cycle(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("pre_reset_flush", 32'(flush), 1);
    reset = 1'b0;
    #1;
    check_reset_vals();
    mq.delete();
    eq.delete();
    #2;
    reset = 1'b1;
    sweep();

`ifdef BRCTRL_STATS_EN
    check("stat_res_clr", 32'(stat_resolved), 0);
    check("stat_mis_clr", 32'(stat_mispred), 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 6'(i + 1), 1'b1, 32'h10, 1'b0, 1'b0);
      cycle(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 6'(i + 50), 1'b0, 32'h20, 1'b0, 1'b0);
      cycle(1'b0, 6'd0, 1'b0, 32'h0, 1'b1, 1'b1);
      flush_out();
    end
    check("stat_resolved", 32'(stat_resolved), 5);
    check("stat_mispred", 32'(stat_mispred), 2);
`endif

    check("scoreboard_empty", 32'(eq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
